uart_rx_frame: RTL

- Serial receiver that is the other end of the team's Tx block; decodes the Tx frame format back into parallel data.
- Line rate is one bit per `clk`: the line is sampled once per rising edge, with no oversampling.
- Frame: start bit (0), data bits LSB first, an optional parity bit, then 1 or 2 stop bits (1).
- Delivers each frame as a byte plus status flags through a valid/ack holding register.

---
 rtl/uart_rx_frame_if.sv | 27 ++
 rtl/uart_rx_frame.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Serial-line and parallel-frame signals between the UART receiver and its environment.
// The slave modport is the receiver; the master modport drives the line and consumes frames.
interface uart_rx_frame_if #(
  parameter int unsigned MAXD = 8
);
  logic            din;
  logic [1:0]      par;
  logic            snum;
  logic            dnum;
  logic            ack;
  logic [MAXD-1:0] dout;
  logic            valid;
  logic            par_err;
  logic            frm_err;
  logic            ovr_err;
  logic            busy;

  modport master (
    output din, par, snum, dnum, ack,
    input  dout, valid, par_err, frm_err, ovr_err, busy
  );

  modport slave (
    input  din, par, snum, dnum, ack,
    output dout, valid, par_err, frm_err, ovr_err, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver, one line bit per clock: start, LSB-first data, optional parity,
// 1 or 2 stop bits. Completed frames are held in a valid/ack register with error flags.
module uart_rx_frame #(
  parameter int unsigned MAXD = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_frame_if.slave bus
);

  localparam int unsigned CW = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StData   = 3'd1;
  localparam logic [2:0] StParity = 3'd2;
  localparam logic [2:0] StStop1  = 3'd3;
  localparam logic [2:0] StStop2  = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  localparam logic [CW-1:0] LastFull  = CW'(MAXD - 1);
  localparam logic [CW-1:0] LastShort = CW'(MAXD - 2);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MAXD-1:0] sh_q, sh_d;
  logic [1:0]      cfg_par_q, cfg_par_d;
  logic            cfg_snum_q, cfg_snum_d;
  logic            cfg_dnum_q, cfg_dnum_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic [MAXD-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            par_err_q, par_err_d;
  logic            frm_err_q, frm_err_d;
  logic            ovr_err_q, ovr_err_d;
  logic            busy_q, busy_d;
  logic            done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    cfg_par_d  = cfg_par_q;
    cfg_snum_d = cfg_snum_q;
    cfg_dnum_d = cfg_dnum_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!bus.din) begin
          state_d    = StData;
          cnt_d      = '0;
          sh_d       = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          cfg_par_d  = bus.par;
          cfg_snum_d = bus.snum;
          cfg_dnum_d = bus.dnum;
        end
      end
      StData: begin
        // Bits land at their final position, so a short frame leaves the MSB at 0.
        sh_d[cnt_q] = bus.din;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == (cfg_dnum_q ? LastShort : LastFull)) begin
          state_d = cfg_par_q[1] ? StParity : StStop1;
        end
      end
      StParity: begin
        if (bus.din != ((^sh_q) ^ cfg_par_q[0])) perr_d = 1'b1;
        state_d = StStop1;
      end
      StStop1: begin
        if (!bus.din) ferr_d = 1'b1;
        if (cfg_snum_q) done = 1'b1;
        else            state_d = StStop2;
      end
      StStop2: begin
        if (!bus.din) ferr_d = 1'b1;
        done = 1'b1;
      end
      StBreak: begin
        if (bus.din) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A framing error means the line may be held low; wait it out instead of decoding zeros.
    if (done) state_d = ferr_d ? StBreak : StIdle;
  end

  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;
    if (done) begin
      dout_d    = sh_q;
      par_err_d = perr_q;
      frm_err_d = ferr_d;
      valid_d   = 1'b1;
      if (valid_q) ovr_err_d = !bus.ack;
    end else if (valid_q && bus.ack) begin
      valid_d   = 1'b0;
      ovr_err_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      cfg_par_q  <= '0;
      cfg_snum_q <= 1'b0;
      cfg_dnum_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      cfg_par_q  <= cfg_par_d;
      cfg_snum_q <= cfg_snum_d;
      cfg_dnum_q <= cfg_dnum_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.valid   = valid_q;
  assign bus.par_err = par_err_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovr_err = ovr_err_q;
  assign bus.busy    = busy_q;

endmodule
